// File: rtl/weight_shadow_bank.sv
// Double-buffered weight tile: rows are extended and collected in a shadow bank,
// then swapped into the active bank on request. Optional macro: WEIGHT_PARTIAL_ACTIVATE_EN.
module weight_shadow_bank #(
   parameter int MATRIX_WIDTH = 14,
   parameter int BYTE_WIDTH   = 8
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               enable,
   input  logic                                               load_weight,
   input  logic [BYTE_WIDTH-1:0]                              weight_addr,
   input  logic                                               is_weight_signed,
   input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]                 weight_data,
   input  logic                                               activate,
   output logic [MATRIX_WIDTH*MATRIX_WIDTH*(BYTE_WIDTH+1)-1:0] active_weights,
   output logic                                               active_valid,
   output logic                                               shadow_full,
   output logic                                               activate_pending,
   output logic                                               swap_done,
   output logic                                               addr_error
);

   localparam int EW     = BYTE_WIDTH + 1;
   localparam int ROW_W  = MATRIX_WIDTH * EW;
   localparam int TILE_W = MATRIX_WIDTH * ROW_W;
   localparam int IN_W   = MATRIX_WIDTH * BYTE_WIDTH;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_FULL
   } state_t;

   // Widen every byte of a raw row to EW bits, sign- or zero-extending as a unit.
   function automatic logic [ROW_W-1:0] extend_row(input logic [IN_W-1:0] raw,
                                                   input logic            sgn);
      logic [ROW_W-1:0]      r;
      logic [BYTE_WIDTH-1:0] b;
      r = '0;
      for (int j = 0; j < MATRIX_WIDTH; j++) begin
         b = raw[j*BYTE_WIDTH +: BYTE_WIDTH];
         r[j*EW +: EW] = {sgn & b[BYTE_WIDTH-1], b};
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [MATRIX_WIDTH-1:0] bitmap_q, bitmap_d;
   logic [ROW_W-1:0]        shadow_q [MATRIX_WIDTH];
   logic [ROW_W-1:0]        shadow_d [MATRIX_WIDTH];
   logic [TILE_W-1:0]       active_q, active_d;
   logic                    active_valid_q, active_valid_d;
   logic                    shadow_full_q, shadow_full_d;
   logic                    pending_q, pending_d;
   logic                    swap_done_q, swap_done_d;
   logic                    addr_error_q, addr_error_d;

   logic                    addr_ok;
   logic                    wr_en;
   logic                    swap;
   logic [ROW_W-1:0]        row_ext;
   logic [MATRIX_WIDTH-1:0] row_onehot;

   always_comb begin
      addr_ok = (weight_addr < BYTE_WIDTH'(MATRIX_WIDTH));
      wr_en   = enable & load_weight & addr_ok;
      row_ext = extend_row(weight_data, is_weight_signed);
`ifdef WEIGHT_PARTIAL_ACTIVATE_EN
      swap    = enable & pending_q;
`else
      swap    = enable & pending_q & (state_q == ST_FULL);
`endif

      row_onehot = '0;
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
         row_onehot[i] = wr_en & (weight_addr == BYTE_WIDTH'(i));
      end

      // The swap reads the pre-write shadow, so a same-edge load lands in the new fill.
      shadow_d = shadow_q;
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
         if (row_onehot[i]) begin
            shadow_d[i] = row_ext;
         end
      end

      active_d = active_q;
      if (swap) begin
         for (int i = 0; i < MATRIX_WIDTH; i++) begin
`ifdef WEIGHT_PARTIAL_ACTIVATE_EN
            active_d[i*ROW_W +: ROW_W] = bitmap_q[i] ? shadow_q[i] : '0;
`else
            active_d[i*ROW_W +: ROW_W] = shadow_q[i];
`endif
         end
      end

      bitmap_d = swap ? '0 : bitmap_q;
      bitmap_d = bitmap_d | row_onehot;

      if (bitmap_d == '0) begin
         state_d = ST_EMPTY;
      end else if (&bitmap_d) begin
         state_d = ST_FULL;
      end else begin
         state_d = ST_FILLING;
      end

      // A request arriving while one is pending, or during the swap, is absorbed.
      pending_d = pending_q;
      if (enable) begin
         if (swap) begin
            pending_d = 1'b0;
         end else if (activate) begin
            pending_d = 1'b1;
         end
      end

      swap_done_d    = enable ? swap : swap_done_q;
      active_valid_d = active_valid_q | swap;
      shadow_full_d  = &bitmap_d;
      addr_error_d   = addr_error_q | (enable & load_weight & ~addr_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_EMPTY;
         bitmap_q       <= '0;
         active_q       <= '0;
         active_valid_q <= 1'b0;
         shadow_full_q  <= 1'b0;
         pending_q      <= 1'b0;
         swap_done_q    <= 1'b0;
         addr_error_q   <= 1'b0;
         for (int i = 0; i < MATRIX_WIDTH; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         bitmap_q       <= bitmap_d;
         active_q       <= active_d;
         active_valid_q <= active_valid_d;
         shadow_full_q  <= shadow_full_d;
         pending_q      <= pending_d;
         swap_done_q    <= swap_done_d;
         addr_error_q   <= addr_error_d;
         for (int i = 0; i < MATRIX_WIDTH; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign active_weights   = active_q;
   assign active_valid     = active_valid_q;
   assign shadow_full      = shadow_full_q;
   assign activate_pending = pending_q;
   assign swap_done        = swap_done_q;
   assign addr_error       = addr_error_q;

endmodule

// File: tb/tb_weight_shadow_bank.sv
// Bench for weight_shadow_bank: directed loads/activates, expected tiles queued
// at issue time and compared by a monitor on each swap_done.
module tb_weight_shadow_bank;

   localparam int MW     = 14;
   localparam int BW     = 8;
   localparam int EW     = BW + 1;
   localparam int ROW_W  = MW * EW;
   localparam int TILE_W = MW * ROW_W;
   localparam int IN_W   = MW * BW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b1;
   logic              load_weight = 1'b0;
   logic [BW-1:0]     weight_addr = '0;
   logic              is_weight_signed = 1'b0;
   logic [IN_W-1:0]   weight_data = '0;
   logic              activate = 1'b0;
   logic [TILE_W-1:0] active_weights;
   logic              active_valid;
   logic              shadow_full;
   logic              activate_pending;
   logic              swap_done;
   logic              addr_error;

   weight_shadow_bank #(.MATRIX_WIDTH(MW), .BYTE_WIDTH(BW)) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .load_weight      (load_weight),
      .weight_addr      (weight_addr),
      .is_weight_signed (is_weight_signed),
      .weight_data      (weight_data),
      .activate         (activate),
      .active_weights   (active_weights),
      .active_valid     (active_valid),
      .shadow_full      (shadow_full),
      .activate_pending (activate_pending),
      .swap_done        (swap_done),
      .addr_error       (addr_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [TILE_W-1:0] exp_q [$];
   logic [ROW_W-1:0]  model_shadow [MW];
   logic [MW-1:0]     model_bitmap = '0;
   logic [TILE_W-1:0] last_tile = '0;

   function automatic logic [ROW_W-1:0] ext(input logic [BW-1:0] b, input logic s);
      logic [ROW_W-1:0] r;
      for (int j = 0; j < MW; j++) r[j*EW +: EW] = {s & b[BW-1], b};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_row(input string name, input int row, input logic [ROW_W-1:0] exp);
      checks++;
      if (active_weights[row*ROW_W +: ROW_W] !== exp) begin
         failures++;
         $display("FAIL %s row %0d got %h want %h", name, row,
                  active_weights[row*ROW_W +: ROW_W], exp);
      end
   endtask

   task automatic chk_tile(input string name, input logic [TILE_W-1:0] exp);
      int bad;
      bad = -1;
      for (int i = 0; i < MW; i++)
         if (bad < 0 && active_weights[i*ROW_W +: ROW_W] !== exp[i*ROW_W +: ROW_W]) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s row %0d got %h want %h", name, bad,
                  active_weights[bad*ROW_W +: ROW_W], exp[bad*ROW_W +: ROW_W]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_row(input int addr, input logic [BW-1:0] b, input logic s);
      load_weight      = 1'b1;
      weight_addr      = BW'(addr);
      is_weight_signed = s;
      weight_data      = {MW{b}};
      if (addr < MW) begin
         model_shadow[addr] = ext(b, s);
         model_bitmap[addr] = 1'b1;
      end
      tick();
      load_weight = 1'b0;
   endtask

   task automatic pulse_act();
      activate = 1'b1;
      tick();
      activate = 1'b0;
   endtask

   task automatic expect_swap();
      logic [TILE_W-1:0] t;
      t = '0;
      for (int i = 0; i < MW; i++) begin
`ifdef WEIGHT_PARTIAL_ACTIVATE_EN
         if (model_bitmap[i]) t[i*ROW_W +: ROW_W] = model_shadow[i];
`else
         t[i*ROW_W +: ROW_W] = model_shadow[i];
`endif
      end
      exp_q.push_back(t);
      last_tile    = t;
      model_bitmap = '0;
   endtask

   always @(negedge clk) begin
      if (!rst && swap_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_swap got swap_done=1 want no swap");
         end else begin
            logic [TILE_W-1:0] e;
            e = exp_q.pop_front();
            chk_tile("swap_tile", e);
            chk("swap_active_valid", 64'(active_valid), 64'd1);
            chk("swap_shadow_full", 64'(shadow_full), 64'd0);
         end
      end
   end

   initial begin
      logic [TILE_W-1:0] prev_tile;
      logic [ROW_W-1:0]  r;
      for (int i = 0; i < MW; i++) model_shadow[i] = '0;

      tick();
      tick();
      chk("rst_active_weights_zero", 64'(active_weights == '0), 64'd1);
      chk("rst_flags", {58'd0, active_valid, shadow_full, activate_pending, swap_done, addr_error, 1'b0}, 64'd0);
      rst = 1'b0;
      tick();

      // Full load, row i = i+1 unsigned
      for (int i = 0; i < MW; i++) load_row(i, BW'(i + 1), 1'b0);
      chk("full_shadow_full", 64'(shadow_full), 64'd1);
      expect_swap();
      pulse_act();
      chk("full_pending", 64'(activate_pending), 64'd1);
      chk("full_no_early_swap", 64'(swap_done), 64'd0);
      tick();
      chk("full_swap_latency", 64'(swap_done), 64'd1);
      tick();
      r = {MW{9'h006}};
      chk_row("full_row5", 5, r);
      chk("full_valid", 64'(active_valid), 64'd1);
      chk("full_shadow_cleared", 64'(shadow_full), 64'd0);
      chk("full_pulse_once", 64'(swap_done), 64'd0);

      // Enable low: activate is lost
      enable = 1'b0;
      activate = 1'b1;
      tick();
      activate = 1'b0;
      enable = 1'b1;
      tick();
      chk("enable_low_no_pending", 64'(activate_pending), 64'd0);

      // Sign extension with a mix of signed and unsigned rows
      for (int i = 0; i < MW; i++) begin
         if (i == 3) load_row(i, 8'hFF, 1'b1);
         else if (i == 4) load_row(i, 8'hFF, 1'b0);
         else load_row(i, BW'(8'h80 + i), i[0]);
      end
      expect_swap();
      pulse_act();
      tick();
      tick();
      r = {MW{9'h1FF}};
      chk_row("sign_row3", 3, r);
      r = {MW{9'h0FF}};
      chk_row("unsigned_row4", 4, r);
      r = {MW{9'h181}};
      chk_row("signed_row1", 1, r);

`ifndef WEIGHT_PARTIAL_ACTIVATE_EN
      // Early activate waits for the tile to complete
      prev_tile = last_tile;
      for (int i = 0; i < 10; i++) load_row(i, BW'(8'h10 + i), 1'b1);
      pulse_act();
      for (int k = 0; k < 3; k++) tick();
      chk("early_pending_held", 64'(activate_pending), 64'd1);
      for (int i = 10; i < 13; i++) load_row(i, BW'(8'hF0 + i), 1'b1);
      chk_tile("early_old_tile_held", prev_tile);
      load_row(13, 8'h7E, 1'b1);
      expect_swap();
      chk("early_full_rise", 64'(shadow_full), 64'd1);
      chk("early_no_swap_yet", 64'(swap_done), 64'd0);
      tick();
      chk("early_swap_after_full", 64'(swap_done), 64'd1);
      tick();
`endif

      // Bad addresses: 29 would alias row 13 if truncated
      for (int i = 0; i < 13; i++) load_row(i, BW'(8'h20 + i), 1'b0);
      load_row(29, 8'h55, 1'b0);
      load_row(14, 8'h66, 1'b0);
      tick();
      chk("bad_addr_no_full", 64'(shadow_full), 64'd0);
      chk("bad_addr_error", 64'(addr_error), 64'd1);
      load_row(13, 8'h2D, 1'b0);
      chk("bad_addr_then_full", 64'(shadow_full), 64'd1);
      chk("bad_addr_sticky", 64'(addr_error), 64'd1);

      // Overlap: row 0 loaded on the swap edge
      expect_swap();
      pulse_act();
      load_row(0, 8'hA5, 1'b1);
      chk("overlap_swap_edge", 64'(swap_done), 64'd1);
      r = {MW{9'h020}};
      chk_row("overlap_old_row0", 0, r);
      chk("overlap_not_full", 64'(shadow_full), 64'd0);
      for (int i = 1; i < 13; i++) load_row(i, BW'(8'h30 + i), 1'b0);
      chk("overlap_13_rows_not_full", 64'(shadow_full), 64'd0);
      load_row(13, 8'h3D, 1'b0);
      chk("overlap_bitmap_kept_row0", 64'(shadow_full), 64'd1);
      expect_swap();
      pulse_act();
      tick();
      tick();
      r = {MW{9'h1A5}};
      chk_row("overlap_new_row0", 0, r);

      // Reset mid-pending
      for (int i = 0; i < 7; i++) load_row(i, BW'(8'h50 + i), 1'b0);
      pulse_act();
`ifndef WEIGHT_PARTIAL_ACTIVATE_EN
      chk("rst_mid_pending_set", 64'(activate_pending), 64'd1);
`endif
      rst = 1'b1;
      exp_q.delete();
      tick();
      chk("rst2_active_weights_zero", 64'(active_weights == '0), 64'd1);
      chk("rst2_flags", {58'd0, active_valid, shadow_full, activate_pending, swap_done, addr_error, 1'b0}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < MW; i++) model_shadow[i] = '0;
      model_bitmap = '0;
      tick();
      tick();
      chk("rst2_pending_discarded", 64'(activate_pending), 64'd0);
`ifdef WEIGHT_PARTIAL_ACTIVATE_EN
      for (int i = 0; i < 7; i++) load_row(i, BW'(8'h60 + i), 1'b0);
      expect_swap();
      pulse_act();
      tick();
      tick();
      chk_row("partial_row7_zero", 7, '0);
`endif
      for (int i = 0; i < MW; i++) load_row(i, BW'(8'h40 + i), 1'b0);
      expect_swap();
      pulse_act();
      tick();
      chk("rst2_swap", 64'(swap_done), 64'd1);
      tick();
      r = {MW{9'h04D}};
      chk_row("rst2_row13", 13, r);

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
